// File: rtl/ex_muldiv_pkg.sv
// Shared constants and encodings for the EX-stage HI/LO unit (multiply, divide, MTHI/MTLO).
package ex_muldiv_pkg;

  localparam int REG_W = 32;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic WRITE_EN  = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ON   = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Iterative restoring radix-2 divider: operand latch, one step per cycle, sign fix-up.
//   state    | meaning
//   DIV_IDLE | waiting for a divide start
//   DIV_ON   | 32 shift/subtract steps in progress
//   DIV_ZERO | divisor was zero, result forced to 0
//   DIV_END  | result valid for one cycle
module ex_muldiv_div_iter
  import ex_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [REG_W-1:0] dividend_i,
  input  logic [REG_W-1:0] divisor_i,
  output div_state_e       state_o,
  output logic [REG_W-1:0] quot_o,
  output logic [REG_W-1:0] rem_o
);

  div_state_e       state_q;
  logic [5:0]       cnt_q;
  logic [REG_W-1:0] dvd_q, dvs_q, part_q;
  logic             sdvd_q, sdvs_q;
  logic [REG_W-1:0] quot_q, rem_q;

  logic [REG_W:0]   trial;
  logic             fits;
  logic [REG_W-1:0] diff, part_d, dvd_d, quot_fix, rem_fix;

  // Shifted partial remainder is always below 2*divisor, so the 32-bit difference is exact when it fits.
  assign trial    = {part_q, dvd_q[REG_W-1]};
  assign fits     = trial >= {1'b0, dvs_q};
  assign diff     = trial[REG_W-1:0] - dvs_q;
  assign part_d   = fits ? diff : trial[REG_W-1:0];
  assign dvd_d    = {dvd_q[REG_W-2:0], fits};
  assign quot_fix = (sdvd_q ^ sdvs_q) ? (~dvd_d + 1'b1) : dvd_d;
  assign rem_fix  = sdvd_q ? (~part_d + 1'b1) : part_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= ZERO_WORD;
      dvs_q   <= ZERO_WORD;
      part_q  <= ZERO_WORD;
      sdvd_q  <= 1'b0;
      sdvs_q  <= 1'b0;
      quot_q  <= ZERO_WORD;
      rem_q   <= ZERO_WORD;
    end else if (annul_i && state_q != DIV_IDLE) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: if (start_i) begin
          cnt_q   <= '0;
          part_q  <= ZERO_WORD;
          sdvd_q  <= signed_i & dividend_i[REG_W-1];
          sdvs_q  <= signed_i & divisor_i[REG_W-1];
          dvd_q   <= (signed_i && dividend_i[REG_W-1]) ? (~dividend_i + 1'b1) : dividend_i;
          dvs_q   <= (signed_i && divisor_i[REG_W-1]) ? (~divisor_i + 1'b1) : divisor_i;
          state_q <= (divisor_i == ZERO_WORD) ? DIV_ZERO : DIV_ON;
        end
        DIV_ON: begin
          part_q <= part_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            quot_q  <= quot_fix;
            rem_q   <= rem_fix;
            state_q <= DIV_END;
          end
        end
        DIV_ZERO: begin
          quot_q  <= ZERO_WORD;
          rem_q   <= ZERO_WORD;
          state_q <= DIV_END;
        end
        DIV_END: state_q <= DIV_IDLE;
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign quot_o  = quot_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: single-cycle multiply and MTHI/MTLO, multi-cycle divide with pipeline stall.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_i,
  input  logic [REG_W-1:0] reg1_i,
  input  logic [REG_W-1:0] reg2_i,
  input  logic [REG_W-1:0] hi_i,
  input  logic [REG_W-1:0] lo_i,
  input  logic             annul_i,
  output logic             whilo_o,
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o,
  output logic             stallreq_o
);

  op_e                op;
  div_state_e         div_state;
  logic [REG_W-1:0]   div_quot, div_rem;
  logic               div_start;
  logic [2*REG_W-1:0] prod_s, prod_u;

  assign op        = op_e'(op_i);
  assign div_start = (op == OP_DIV || op == OP_DIVU) && !annul_i;

  // Operands widened to 64 bits so the truncated product is the exact full product.
  assign prod_s = {{REG_W{reg1_i[REG_W-1]}}, reg1_i} * {{REG_W{reg2_i[REG_W-1]}}, reg2_i};
  assign prod_u = {{REG_W{1'b0}}, reg1_i} * {{REG_W{1'b0}}, reg2_i};

  ex_muldiv_div_iter div_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .signed_i  (op == OP_DIV),
    .annul_i   (annul_i),
    .dividend_i(reg1_i),
    .divisor_i (reg2_i),
    .state_o   (div_state),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

  always_comb begin
    whilo_o    = WRITE_DIS;
    hi_o       = hi_i;
    lo_o       = lo_i;
    stallreq_o = 1'b0;
    if (rst) begin
      hi_o = ZERO_WORD;
      lo_o = ZERO_WORD;
    end else begin
      case (div_state)
        DIV_IDLE: if (!annul_i) begin
          case (op)
            OP_MULT:  begin {hi_o, lo_o} = prod_s; whilo_o = WRITE_EN; end
            OP_MULTU: begin {hi_o, lo_o} = prod_u; whilo_o = WRITE_EN; end
            OP_MTHI:  begin hi_o = reg1_i; whilo_o = WRITE_EN; end
            OP_MTLO:  begin lo_o = reg1_i; whilo_o = WRITE_EN; end
            OP_DIV, OP_DIVU: stallreq_o = 1'b1;
            default: ;
          endcase
        end
        DIV_ON, DIV_ZERO: stallreq_o = !annul_i;
        DIV_END: if (!annul_i) begin
          whilo_o = WRITE_EN;
          hi_o    = div_rem;
          lo_o    = div_quot;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv against an arithmetic reference of the HI/LO operations.
module tb_ex_muldiv;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, OP7 = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic        annul_i;
  logic        whilo_o, stallreq_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .op_i      (op_i),
    .reg1_i    (reg1_i),
    .reg2_i    (reg2_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .annul_i   (annul_i),
    .whilo_o   (whilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stallreq_o(stallreq_o)
  );

  function automatic void ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (op == DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pu;
    if (op == MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    pu = {32'd0, a} * {32'd0, b};
    return pu;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_i = MULT; reg1_i = 32'h1234_5678; reg2_i = 32'h9abc_def0;
    hi_i = 32'hdead_beef; lo_i = 32'hcafe_f00d; annul_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
        errors++;
        $display("FAIL reset_outputs: got whilo=%b stall=%b hi=%h lo=%h, want all 0", whilo_o, stallreq_o, hi_o, lo_o);
      end
      next_cycle();
    end
    rst = 1'b0; op_i = NOP;
    @(negedge clk);
    checks++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== hi_i || lo_o !== lo_i) begin
      errors++;
      $display("FAIL reset_release_idle: got whilo=%b stall=%b hi=%h lo=%h", whilo_o, stallreq_o, hi_o, lo_o);
    end
    next_cycle();
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      if (i < 2) begin
        a = 32'hFFFF_FFFE; b = 32'h0000_0003; op = (i == 0) ? MULT : MULTU;
      end else begin
        a = $urandom; b = $urandom; op = ($urandom_range(0, 1) == 0) ? MULT : MULTU;
        if (i % 6 == 0) a = 32'h8000_0000;
      end
      if (i == 0) exp = 64'hFFFF_FFFF_FFFF_FFFA;
      else if (i == 1) exp = 64'h0000_0002_FFFF_FFFA;
      else exp = ref_mul(op, a, b);
      op_i = op; reg1_i = a; reg2_i = b; hi_i = $urandom; lo_i = $urandom; annul_i = 1'b0;
      @(negedge clk);
      checks++;
      if (whilo_o !== 1'b1 || stallreq_o !== 1'b0 || {hi_o, lo_o} !== exp) begin
        errors++;
        $display("FAIL mult[%0d] op=%0d a=%h b=%h: got whilo=%b stall=%b hi:lo=%h, want 1 0 %h",
                 i, op, a, b, whilo_o, stallreq_o, {hi_o, lo_o}, exp);
      end
      next_cycle();
    end
    op_i = NOP;
  endtask

  task automatic test_passthrough();
    logic [2:0]  ops [6] = '{MTHI, MTLO, NOP, OP7, MULT, DIV};
    logic        ann [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        ew;
    logic [31:0] ehi, elo;
    for (int i = 0; i < 6; i++) begin
      op_i = ops[i]; annul_i = ann[i];
      reg1_i = $urandom; reg2_i = $urandom | 32'd1; hi_i = $urandom; lo_i = $urandom;
      ew = 1'b0; ehi = hi_i; elo = lo_i;
      if (!annul_i && op_i == MTHI) begin ew = 1'b1; ehi = reg1_i; end
      if (!annul_i && op_i == MTLO) begin ew = 1'b1; elo = reg1_i; end
      @(negedge clk);
      checks++;
      if (whilo_o !== ew || stallreq_o !== 1'b0 || hi_o !== ehi || lo_o !== elo) begin
        errors++;
        $display("FAIL passthru[%0d] op=%0d annul=%b: got whilo=%b stall=%b hi=%h lo=%h, want %b 0 %h %h",
                 i, op_i, annul_i, whilo_o, stallreq_o, hi_o, lo_o, ew, ehi, elo);
      end
      next_cycle();
    end
    op_i = NOP; annul_i = 1'b0;
    @(negedge clk);
    checks++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL annulled_div_no_start: got stall=%b whilo=%b, want 0 0", stallreq_o, whilo_o);
    end
    next_cycle();
  endtask

  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int stalls = 0;
    int exp_stalls;
    ref_div(op, a, b, eq, er);
    exp_stalls = (b == 32'd0) ? 2 : 33;
    op_i = op; reg1_i = a; reg2_i = b; annul_i = 1'b0; hi_i = $urandom; lo_i = $urandom;
    @(negedge clk);
    while (stallreq_o === 1'b1 && stalls < 40) begin
      stalls++;
      checks++;
      if (whilo_o !== 1'b0) begin
        errors++;
        $display("FAIL div_whilo_in_stall op=%0d a=%h b=%h cycle %0d: got whilo=%b, want 0", op, a, b, stalls, whilo_o);
      end
      next_cycle();
      reg1_i = $urandom; reg2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
      @(negedge clk);
    end
    checks++;
    if (stalls != exp_stalls) begin
      errors++;
      $display("FAIL div_stall_len op=%0d a=%h b=%h: got %0d cycles, want %0d", op, a, b, stalls, exp_stalls);
    end
    checks++;
    if (whilo_o !== 1'b1 || lo_o !== eq || hi_o !== er) begin
      errors++;
      $display("FAIL div_result op=%0d a=%h b=%h: got whilo=%b lo=%h hi=%h, want 1 %h %h",
               op, a, b, whilo_o, lo_o, hi_o, eq, er);
    end
    next_cycle();
    op_i = NOP;
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    run_div(DIV, 32'hFFFF_FFF9, 32'd2);
    run_div(DIVU, 32'd100, 32'd0);
    run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(DIV, 32'd7, 32'hFFFF_FFFE);
    run_div(DIVU, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      run_div(($urandom_range(0, 1) == 0) ? DIV : DIVU, a, b);
    end
  endtask

  task automatic test_annul();
    op_i = DIVU; reg1_i = 32'd1000; reg2_i = 32'd7; annul_i = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      if (i == 10) annul_i = 1'b1;
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (stallreq_o !== 1'b1) begin
          errors++;
          $display("FAIL annul_pre_stall: got stall=%b, want 1", stallreq_o);
        end
      end
    end
    checks++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_cycle: got stall=%b whilo=%b, want 0 0", stallreq_o, whilo_o);
    end
    next_cycle();
    annul_i = 1'b0; op_i = MTLO; reg1_i = 32'h0000_1234; hi_i = $urandom; lo_i = $urandom;
    @(negedge clk);
    checks++;
    if (whilo_o !== 1'b1 || stallreq_o !== 1'b0 || lo_o !== 32'h0000_1234 || hi_o !== hi_i) begin
      errors++;
      $display("FAIL annul_then_mtlo: got whilo=%b stall=%b hi=%h lo=%h, want 1 0 %h 00001234",
               whilo_o, stallreq_o, hi_o, lo_o, hi_i);
    end
    next_cycle();
    op_i = NOP;
  endtask

  task automatic test_reset_mid_div();
    op_i = DIVU; reg1_i = 32'd50; reg2_i = 32'd3; annul_i = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      if (i == 5) rst = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({whilo_o, stallreq_o, hi_o, lo_o} !== 66'd0) begin
      errors++;
      $display("FAIL rst_mid_div: got whilo=%b stall=%b hi=%h lo=%h, want all 0", whilo_o, stallreq_o, hi_o, lo_o);
    end
    next_cycle();
    rst = 1'b0; op_i = NOP;
    @(negedge clk);
    checks++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== hi_i || lo_o !== lo_i) begin
      errors++;
      $display("FAIL rst_then_idle: got stall=%b whilo=%b hi=%h lo=%h", stallreq_o, whilo_o, hi_o, lo_o);
    end
    next_cycle();
    run_div(DIVU, 32'd9, 32'd4);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_passthrough();
    test_div();
    test_annul();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 op_i  input  3  HI/LO operation; codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 treated as NOP.
REQ-004 reg1_i  input  32  rs operand, forwarded (dividend / multiplicand / MTHI/MTLO source).
REQ-005 reg2_i  input  32  rt operand, forwarded (divisor / multiplier).
REQ-006 hi_i  input  32  current HI, already forwarded from MEM/WB.
REQ-007 lo_i  input  32  current LO, already forwarded from MEM/WB.
REQ-008 annul_i  input  1  flush of the EX instruction; aborts any division.
REQ-009 whilo_o  output  1  HI/LO write enable toward the EX/MEM register.
REQ-010 hi_o  output  32  HI value to write.
REQ-011 lo_o  output  32  LO value to write.
REQ-012 stallreq_o  output  1  pipeline stall request; holds PC..EX while high.

Function
REQ-013 States: IDLE, DIV_ON, DIV_ZERO, DIV_END; only DIV/DIVU leave IDLE.
REQ-014 IDLE, MULT: combinational; {hi_o,lo_o} = signed 32x32 -> 64 product; whilo_o=1 same cycle.
REQ-015 IDLE, MULTU: same as REQ-014, unsigned.
REQ-016 IDLE, MTHI: hi_o=reg1_i, lo_o=lo_i, whilo_o=1; MTLO: hi_o=hi_i, lo_o=reg1_i, whilo_o=1.
REQ-017 IDLE, NOP or annul_i=1: whilo_o=0, hi_o=hi_i, lo_o=lo_i, stallreq_o=0.
REQ-018 IDLE, DIV/DIVU, annul_i=0: stallreq_o=1 combinationally; next state DIV_ZERO if reg2_i==0, else DIV_ON with counter=0 and operands latched.
REQ-019 DIV latching: magnitudes of both operands (two's complement negation if negative); signs of dividend and divisor saved; DIVU latches raw values, signs cleared.
REQ-020 DIV_ON: one restoring radix-2 step per cycle (33-bit trial subtract, shift in quotient bit); counter increments; after the 32nd step next state DIV_END; stallreq_o=1.
REQ-021 DIV_ZERO: one cycle, quotient=0, remainder=0, next state DIV_END; stallreq_o=1.
REQ-022 DIV_END: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; next state IDLE unconditionally.
REQ-023 Sign fix-up (DIV): quotient negated iff dividend and divisor signs differ; remainder takes dividend sign; 32-bit wrap, so 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-024 Latency: non-zero divide stalls 33 cycles (IDLE + 32 DIV_ON); result in 34th cycle; divide-by-zero stalls 2 cycles, result in 3rd.
REQ-025 Operands ignored after latching; reg1_i/reg2_i changes during DIV_ON do not affect the result.
REQ-026 annul_i=1 in any non-IDLE state: next state IDLE, whilo_o=0 and stallreq_o=0 that cycle, no result.
REQ-027 whilo_o is never high in DIV_ON or DIV_ZERO.

Reset
REQ-028 rst=1: state IDLE, counter 0, quotient/remainder/latched operands 0.
REQ-029 rst=1 outputs: whilo_o=0, stallreq_o=0, hi_o=0, lo_o=0, overriding op_i.
REQ-030 rst mid-division discards the operation; first cycle after rst released behaves as IDLE.

Structure
REQ-031 Op codes, state encodings, RegBus/ZeroWord/WriteEnable constants in shared define.v.
REQ-032 Iterative divider datapath is one sub-module, div_iter (latch, step, counter, sign fix-up); MULT/MTxx paths stay in ex_muldiv.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003 -> same cycle whilo_o=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> stallreq_o high 33 cycles, then one cycle whilo_o=1, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 DIVU 100 / 0 -> stallreq_o high 2 cycles, 3rd cycle whilo_o=1, HI=0, LO=0.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 after 33 stall cycles.
REQ-037 DIVU 1000/7 started, annul_i pulsed at DIV_ON step 10 -> stallreq_o and whilo_o low that cycle, IDLE next; following MTLO 0x1234 -> LO=0x1234, HI=hi_i.
REQ-038 rst asserted at DIV_ON step 5 -> all outputs 0 next cycle; subsequent DIVU 9/4 completes with LO=2, HI=1.
